// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial word transmitter with a reference
// "prefix divisible by MOD" flag for in-system detector checking.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word valid
//   in_data    W-bit word, sampled only on in_valid & in_ready
//   in_ready   block can accept a word this cycle
//   ser_bit    serial data, MSB-first, 0 when ser_valid is low
//   ser_valid  ser_bit carries a word bit this cycle
//   ser_last   high with the LSB of a word
//   exp_y      registered: prefix value sent so far is 0 mod MOD
//   word_done  one-cycle pulse in the cycle after ser_last
//   word_div   whole-word divisibility, updated with word_done
module serial_word_tx #(
  parameter int W          = 8,
  parameter int MOD        = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         ser_bit,
  output logic         ser_valid,
  output logic         ser_last,
  output logic         exp_y,
  output logic         word_done,
  output logic         word_div
);

  localparam int RW    = ($clog2(MOD) < 1) ? 1 : $clog2(MOD);
  localparam int CW    = ($clog2(W) < 1) ? 1 : $clog2(W);
  localparam int GW    = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int GLAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam bit GAPLESS = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t          state, state_n;
  logic [W-1:0]    shreg, shreg_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [RW-1:0]   res, res_n;
  logic [GW-1:0]   gcnt, gcnt_n;
  logic            exp_y_n, word_done_n, word_div_n;

  logic            last;
  logic            accept;
  logic [RW:0]     r_sum;
  logic [RW-1:0]   r_next;

  assign last   = (cnt == CW'(W - 1));
  assign accept = in_valid & in_ready;

  // 2*r + b is just the residue with the new bit appended; it is always
  // below 2*MOD, so a single conditional subtract completes the modulo.
  assign r_sum  = {res, shreg[W-1]};
  assign r_next = RW'((r_sum >= (RW+1)'(MOD)) ? (r_sum - (RW+1)'(MOD)) : r_sum);

  assign ser_valid = (state == SHIFT);
  assign ser_bit   = ser_valid & shreg[W-1];
  assign ser_last  = ser_valid & last;
  // With no gap, the last-bit cycle also accepts the next word so the
  // stream continues without a hole.
  assign in_ready  = (state == IDLE) || (GAPLESS && (state == SHIFT) && last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      res       <= '0;
      gcnt      <= '0;
      exp_y     <= 1'b0;
      word_done <= 1'b0;
      word_div  <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      res       <= res_n;
      gcnt      <= gcnt_n;
      exp_y     <= exp_y_n;
      word_done <= word_done_n;
      word_div  <= word_div_n;
    end
  end

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    cnt_n       = cnt;
    res_n       = res;
    gcnt_n      = gcnt;
    exp_y_n     = 1'b0;
    word_done_n = 1'b0;
    word_div_n  = word_div;
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_n = in_data;
          cnt_n   = '0;
          res_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        exp_y_n = (r_next == '0);
        shreg_n = shreg << 1;
        cnt_n   = cnt + CW'(1);
        res_n   = r_next;
        if (last) begin
          word_done_n = 1'b1;
          word_div_n  = (r_next == '0);
          cnt_n       = '0;
          if (!GAPLESS) begin
            gcnt_n  = '0;
            state_n = GAP;
          end else if (accept) begin
            shreg_n = in_data;
            res_n   = '0;
            state_n = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      GAP: begin
        if (gcnt == GW'(GLAST)) begin
          state_n = IDLE;
        end else begin
          gcnt_n = gcnt + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_word_tx.sv
module tb_serial_word_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic rdy [3];
  logic sb  [3];
  logic sv  [3];
  logic sl  [3];
  logic ey  [3];
  logic wd  [3];
  logic wdv [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 0: W=8 MOD=4 GAP=0   1: W=8 MOD=4 GAP=2   2: W=8 MOD=3 GAP=0
  serial_word_tx #(.W(8), .MOD(4), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .ser_bit(sb[0]), .ser_valid(sv[0]), .ser_last(sl[0]),
    .exp_y(ey[0]), .word_done(wd[0]), .word_div(wdv[0]));
  serial_word_tx #(.W(8), .MOD(4), .GAP_CYCLES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .ser_bit(sb[1]), .ser_valid(sv[1]), .ser_last(sl[1]),
    .exp_y(ey[1]), .word_done(wd[1]), .word_div(wdv[1]));
  serial_word_tx #(.W(8), .MOD(3), .GAP_CYCLES(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[2]), .ser_bit(sb[2]), .ser_valid(sv[2]), .ser_last(sl[2]),
    .exp_y(ey[2]), .word_done(wd[2]), .word_div(wdv[2]));

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      total++;
      if ({rdy[u], sb[u], sv[u], sl[u], ey[u], wd[u], wdv[u]} !== 7'b1000000) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: got %b want 1000000", u,
                 {rdy[u], sb[u], sv[u], sl[u], ey[u], wd[u], wdv[u]});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One word through DUT u: MSB-first bits, registered exp_y trailing by one
  // cycle, then word_done/word_div. ey_exp is packed in bit order (MSB first).
  task automatic test_single_word(input int u, input string name, input logic [7:0] d,
                                  input logic [7:0] ey_exp, input logic div_exp);
    logic want_y;
    @(negedge clk);
    total++;
    if (rdy[u] !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_idle: got %b want 1", name, rdy[u]);
    end
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      want_y = (i == 0) ? 1'b0 : ey_exp[8 - i];
      total++;
      if ({sv[u], sb[u], sl[u], ey[u], wd[u]} !== {1'b1, d[7 - i], (i == 7), want_y, 1'b0}) begin
        bad++;
        $display("FAIL %s bit%0d v/b/l/y/done: got %b want %b", name, i,
                 {sv[u], sb[u], sl[u], ey[u], wd[u]}, {1'b1, d[7 - i], (i == 7), want_y, 1'b0});
      end
      @(negedge clk);
    end
    total++;
    if ({sv[u], ey[u], wd[u], wdv[u]} !== {1'b0, ey_exp[0], 1'b1, div_exp}) begin
      bad++;
      $display("FAIL %s done v/y/done/div: got %b want %b", name,
               {sv[u], ey[u], wd[u], wdv[u]}, {1'b0, ey_exp[0], 1'b1, div_exp});
    end
    @(negedge clk);
    total++;
    if ({sv[u], ey[u], wd[u], wdv[u], rdy[u]} !== {1'b0, 1'b0, 1'b0, div_exp, 1'b1}) begin
      bad++;
      $display("FAIL %s after v/y/done/div/rdy: got %b want %b", name,
               {sv[u], ey[u], wd[u], wdv[u], rdy[u]}, {1'b0, 1'b0, 1'b0, div_exp, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    logic want_y;
    do_reset();
    total++;
    if ({rdy[0], sv[0]} !== 2'b10) begin
      bad++;
      $display("FAIL b2b idle rdy/v: got %b want 10", {rdy[0], sv[0]});
    end
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 8) in_valid = 1'b0;
      // word 1 (all ones) never gives residue 0; word 2 (zeros) starts from a
      // cleared residue so every prefix is divisible.
      want_y = (k >= 9);
      total++;
      if ({sv[0], sb[0], sl[0], rdy[0], ey[0], wd[0]} !==
          {1'b1, (k < 8), (k == 7 || k == 15), (k == 7 || k == 15), want_y, (k == 8)}) begin
        bad++;
        $display("FAIL b2b cyc%0d v/b/l/rdy/y/done: got %b want %b", k,
                 {sv[0], sb[0], sl[0], rdy[0], ey[0], wd[0]},
                 {1'b1, (k < 8), (k == 7 || k == 15), (k == 7 || k == 15), want_y, (k == 8)});
      end
      if (k == 7) in_data = 8'h00;
    end
    @(negedge clk);
    total++;
    if ({sv[0], rdy[0], ey[0], wd[0], wdv[0]} !== 5'b01111) begin
      bad++;
      $display("FAIL b2b end v/rdy/y/done/div: got %b want 01111",
               {sv[0], rdy[0], ey[0], wd[0], wdv[0]});
    end
  endtask

  task automatic test_gap();
    logic [7:0] w1;
    logic [7:0] w2;
    w1 = 8'h81;
    w2 = 8'h40;
    do_reset();
    in_valid = 1'b1;
    in_data  = w1;
    @(negedge clk);
    in_data = w2;  // changes without a handshake; must not disturb word 1
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({sv[1], sb[1], rdy[1]} !== {1'b1, w1[7 - k], 1'b0}) begin
        bad++;
        $display("FAIL gap word1 bit%0d v/b/rdy: got %b want %b", k,
                 {sv[1], sb[1], rdy[1]}, {1'b1, w1[7 - k], 1'b0});
      end
      @(negedge clk);
    end
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({sv[1], rdy[1]} !== 2'b00) begin
        bad++;
        $display("FAIL gap cyc%0d v/rdy: got %b want 00", g, {sv[1], rdy[1]});
      end
      @(negedge clk);
    end
    total++;
    if ({sv[1], rdy[1]} !== 2'b01) begin
      bad++;
      $display("FAIL gap idle v/rdy: got %b want 01", {sv[1], rdy[1]});
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({sv[1], sb[1], sl[1]} !== {1'b1, w2[7 - k], (k == 7)}) begin
        bad++;
        $display("FAIL gap word2 bit%0d v/b/l: got %b want %b", k,
                 {sv[1], sb[1], sl[1]}, {1'b1, w2[7 - k], (k == 7)});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    // three bits (1,0,1) sent; 4th bit now on the line
    total++;
    if ({sv[0], sb[0]} !== 2'b10) begin
      bad++;
      $display("FAIL midrst pre v/b: got %b want 10", {sv[0], sb[0]});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({sv[0], ey[0], wd[0], rdy[0], sb[0]} !== 5'b00010) begin
      bad++;
      $display("FAIL midrst async v/y/done/rdy/b: got %b want 00010",
               {sv[0], ey[0], wd[0], rdy[0], sb[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if ({wd[0], sv[0], rdy[0]} !== 3'b001) begin
        bad++;
        $display("FAIL midrst idle%0d done/v/rdy: got %b want 001", k, {wd[0], sv[0], rdy[0]});
      end
    end
    test_single_word(0, "midrst_0x0C", 8'h0C, 8'hF1, 1'b1);
  endtask

  initial begin
    test_reset();
    do_reset();
    test_single_word(0, "w8m4_0x0C", 8'h0C, 8'hF1, 1'b1);
    do_reset();
    test_single_word(0, "w8m4_0x05", 8'h05, 8'hF8, 1'b0);
    test_back_to_back();
    test_gap();
    test_reset_mid_word();
    do_reset();
    test_single_word(2, "w8m3_0x09", 8'h09, 8'hF1, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
